rx_frame_release_ctrl: RTL

Read-side sequencer for the receive data/control FIFO pair. It counts the words of each frame written into the FIFOs and queues one descriptor per frame (word count plus CRC verdict). It then drives the FIFO read enable to forward good frames to the client, or to silently drain bad frames. It replaces the simple "read whenever not empty and not waiting on CRC" policy with frame-granular release.

---
 rtl/rx_ctrl_pkg.sv | 23 ++
 rtl/rx_desc_queue.sv | 61 ++++++
 rtl/rx_frame_release_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive frame release controller:
// default sizes, read FSM states, error flag positions and the frame descriptor.
package rx_ctrl_pkg;

  localparam int DEF_LEN_W   = 11;
  localparam int DEF_DESC_AW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } rd_state_e;

  localparam int ERR_DESC_OVF    = 0;
  localparam int ERR_VERDICT_OVR = 1;
  localparam int ERR_ZERO_LEN    = 2;

  typedef struct packed {
    logic                 good;
    logic [DEF_LEN_W-1:0] len;
  } desc_t;

endpackage

// File: rtl/rx_desc_queue.sv
// Small synchronous FIFO holding one descriptor per completed frame.
// A push into a full queue or a pop from an empty one is ignored.
module rx_desc_queue #(
  parameter int DW = 12,
  parameter int AW = 2
) (
  input  logic          rxclk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    full      = (count_r == DEPTH_C);
    empty     = (count_r == {(AW + 1){1'b0}});
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    pop_data  = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rx_frame_release_ctrl.sv
// Frame-granular read sequencer for the receive data/control FIFO pair.
// Optional RX_FRAME_STATS_EN adds saturating good/bad frame counters.
module rx_frame_release_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int DESC_AW = DEF_DESC_AW
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic        fifo_wr_en,
  input  logic        frame_end,
  input  logic        crc_done,
  input  logic        crc_good,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        rx_ready,
  output logic [2:0]  err_flags
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

  logic [LEN_W-1:0] wr_cnt_r;
  logic [LEN_W-1:0] pend_len_r;
  logic             pend_vld_r;
  logic [2:0]       err_r;
  logic             rx_ready_r;
  logic             out_valid_r;
  logic             out_sop_r;
  logic             out_eop_r;
  rd_state_e        state_r;
  rd_state_e        state_s;
  logic [LEN_W-1:0] rd_cnt_r;
  logic [LEN_W-1:0] rd_cnt_s;
  logic             first_r;
  logic             first_s;
  logic             pop_s;
  logic             rd_en_s;
  logic             zero_len_s;
  logic             push_s;
  logic             desc_full_s;
  logic             desc_empty_s;
  desc_t            push_desc_s;
  desc_t            head_desc_s;

  // Descriptor assembly from the pending length and the CRC verdict.
  always_comb begin
    push_s           = crc_done & pend_vld_r;
    push_desc_s.good = crc_good;
    push_desc_s.len  = pend_len_r;
  end

  rx_desc_queue #(
    .DW ($bits(desc_t)),
    .AW (DESC_AW)
  ) u_desc_queue (
    .rxclk     (rxclk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_desc_s),
    .pop       (pop_s),
    .pop_data  (head_desc_s),
    .full      (desc_full_s),
    .empty     (desc_empty_s)
  );

  // Write side: per-frame word count and the frame awaiting its verdict.
  // A verdict in the same cycle as frame_end retires the older frame first.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_cnt_r   <= LEN_ZERO;
      pend_len_r <= LEN_ZERO;
      pend_vld_r <= 1'b0;
    end else begin
      if (frame_end) begin
        wr_cnt_r   <= LEN_ZERO;
        pend_len_r <= wr_cnt_r + LEN_ONE;
        pend_vld_r <= 1'b1;
      end else begin
        if (fifo_wr_en && (wr_cnt_r != {LEN_W{1'b1}})) begin
          wr_cnt_r <= wr_cnt_r + LEN_ONE;
        end
        if (push_s) begin
          pend_vld_r <= 1'b0;
        end
      end
    end
  end

  // Read FSM next-state and read enable.
  always_comb begin
    state_s    = state_r;
    rd_cnt_s   = rd_cnt_r;
    first_s    = first_r;
    pop_s      = 1'b0;
    rd_en_s    = 1'b0;
    zero_len_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!desc_empty_s) begin
          pop_s    = 1'b1;
          rd_cnt_s = head_desc_s.len;
          first_s  = 1'b1;
          if (head_desc_s.len == LEN_ZERO) begin
            zero_len_s = 1'b1;
            state_s    = ST_IDLE;
          end else if (head_desc_s.good) begin
            state_s = ST_FWD;
          end else begin
            state_s = ST_DROP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FWD, ST_DROP: begin
        rd_en_s = ~fifo_empty;
        if (rd_en_s) begin
          rd_cnt_s = rd_cnt_r - LEN_ONE;
          first_s  = 1'b0;
          if (rd_cnt_r == LEN_ONE) begin
            state_s = ST_IDLE;
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Read FSM state and delayed output qualifiers.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rd_cnt_r    <= LEN_ZERO;
      first_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      rd_cnt_r    <= rd_cnt_s;
      first_r     <= first_s;
      out_valid_r <= rd_en_s & (state_r == ST_FWD);
      out_sop_r   <= rd_en_s & (state_r == ST_FWD) & first_r;
      out_eop_r   <= rd_en_s & (state_r == ST_FWD) & (rd_cnt_r == LEN_ONE);
    end
  end

  // Sticky error flags and the upstream flow-control flag.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      err_r      <= 3'b000;
      rx_ready_r <= 1'b1;
    end else begin
      rx_ready_r <= ~desc_full_s;
      if (push_s && desc_full_s) begin
        err_r[ERR_DESC_OVF] <= 1'b1;
      end
      if (frame_end && pend_vld_r && !crc_done) begin
        err_r[ERR_VERDICT_OVR] <= 1'b1;
      end
      if (zero_len_s) begin
        err_r[ERR_ZERO_LEN] <= 1'b1;
      end
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign out_valid  = out_valid_r;
  assign out_sop    = out_sop_r;
  assign out_eop    = out_eop_r;
  assign rx_ready   = rx_ready_r;
  assign err_flags  = err_r;

`ifdef RX_FRAME_STATS_EN
  logic [15:0] good_frames_r;
  logic [15:0] bad_frames_r;

  // Saturating per-verdict frame counters, stepped on each descriptor pop.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      good_frames_r <= 16'd0;
      bad_frames_r  <= 16'd0;
    end else begin
      if (pop_s && head_desc_s.good && (good_frames_r != 16'hFFFF)) begin
        good_frames_r <= good_frames_r + 16'd1;
      end
      if (pop_s && !head_desc_s.good && (bad_frames_r != 16'hFFFF)) begin
        bad_frames_r <= bad_frames_r + 16'd1;
      end
    end
  end

  assign good_frames = good_frames_r;
  assign bad_frames  = bad_frames_r;
`endif

endmodule
